// File: rtl/uiaxism2video_if.sv
// AXI4-Stream video beat bus: tuser marks the first pixel of a frame,
// tlast marks the last pixel of a line.
interface uiaxism2video_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] tdata;
   logic              tuser;
   logic              tlast;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, tuser, tlast, tvalid, input tready);
   modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/uiaxism2video.sv
// AXI4-Stream video to raster video bridge. A free-running timing generator
// paces the output; a small first-word-fall-through FIFO buffers stream beats;
// a two-state lock machine aligns stream frames to raster frames and drops
// back to searching for start-of-frame on any framing error or starvation.
module uiaxism2video #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33
) (
   input  logic              vid_clk_i,
   input  logic              vid_rst_i,
   uiaxism2video_if.slave    s_axis_vid,
   output logic              vid_vs_o,
   output logic              vid_hs_o,
   output logic              vid_de_o,
   output logic [DATA_W-1:0] vid_data_o,
   output logic              locked_o,
   output logic              underflow_o
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CW      = AW + 1;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_EOL    = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic {
      ST_WAIT_SOF = 1'b0,
      ST_RUN      = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] tdata;
      logic              tuser;
      logic              tlast;
   } beat_t;

   logic [HW-1:0]     h_cnt_q, h_cnt_d;
   logic [VW-1:0]     v_cnt_q, v_cnt_d;
   state_t            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ready_en_q, ready_en_d;
   logic              vs_q, vs_d;
   logic              hs_q, hs_d;
   logic              de_q, de_d;
   logic              uf_q, uf_d;
   logic [DATA_W-1:0] data_q, data_d;
   beat_t             fifo_mem_q [FIFO_DEPTH];

   logic              h_last, v_last, active;
   logic              sof_pos, eol_pos;
   logic              full, empty, push, pop;
   beat_t             head, wr_beat;

   // Write side: accept whenever the FIFO has room; reads fall through from the head.
   assign full              = (count_q == CNT_FULL);
   assign empty             = (count_q == '0);
   assign s_axis_vid.tready = ready_en_q & ~full;
   assign push              = s_axis_vid.tvalid & s_axis_vid.tready;
   assign wr_beat           = {s_axis_vid.tdata, s_axis_vid.tuser, s_axis_vid.tlast};
   assign head              = fifo_mem_q[rd_ptr_q];

   // Raster counters and the sync / enable decode of the current position.
   // NOTE: every combinational output gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      h_last  = (h_cnt_q == H_LAST);
      v_last  = (v_cnt_q == V_LAST);
      h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_last) begin
         v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end
      active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      sof_pos = (h_cnt_q == '0) && (v_cnt_q == '0);
      eol_pos = (h_cnt_q == H_EOL);
      hs_d    = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
      vs_d    = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);
      de_d    = active;
   end

   // Lock state machine: decides pop, displayed pixel and error pulse for this position.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      uf_d    = 1'b0;
      data_d  = '0;
      case (state_q)
         ST_WAIT_SOF: begin
            if (!empty) begin
               if (!head.tuser) begin
                  pop = 1'b1;
               end else if (h_last && v_last) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (active) begin
               if (empty) begin
                  uf_d = 1'b1;
               end else if (head.tuser && !sof_pos) begin
                  // Early start of frame stays at the head to begin the next frame.
                  uf_d = 1'b1;
               end else begin
                  pop = 1'b1;
                  if ((head.tuser != sof_pos) || (head.tlast != eol_pos)) begin
                     uf_d = 1'b1;
                  end else begin
                     data_d = head.tdata;
                  end
               end
               if (uf_d) begin
                  state_d = ST_WAIT_SOF;
               end
            end
         end
         default: state_d = ST_WAIT_SOF;
      endcase
   end

   // FIFO bookkeeping; tready is held low until the first clock after reset.
   always_comb begin
      wr_ptr_d   = wr_ptr_q + AW'(push);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      count_d    = count_q + CW'(push) - CW'(pop);
      ready_en_d = 1'b1;
   end

   // State, pointers, counters and registered video outputs.
   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
   always_ff @(posedge vid_clk_i or posedge vid_rst_i) begin
      if (vid_rst_i) begin
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         state_q    <= ST_WAIT_SOF;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ready_en_q <= 1'b0;
         vs_q       <= 1'b0;
         hs_q       <= 1'b0;
         de_q       <= 1'b0;
         uf_q       <= 1'b0;
         data_q     <= '0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ready_en_q <= ready_en_d;
         vs_q       <= vs_d;
         hs_q       <= hs_d;
         de_q       <= de_d;
         uf_q       <= uf_d;
         data_q     <= data_d;
      end
   end

   // FIFO storage, written on every accepted beat.
   // NOTE: storage is not reset; only entries between the read and write pointers are ever used.
   always_ff @(posedge vid_clk_i) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= wr_beat;
      end
   end

   assign vid_vs_o    = vs_q;
   assign vid_hs_o    = hs_q;
   assign vid_de_o    = de_q;
   assign vid_data_o  = data_q;
   assign underflow_o = uf_q;
   assign locked_o    = (state_q == ST_RUN);
endmodule

// File: tb/tb_uiaxism2video.sv
// Bench for uiaxism2video on a 14x7 raster: a reset timing table, directed
// frame scenarios and randomized frames against a cycle-level reference model.
module tb_uiaxism2video;
   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 16;
   localparam int H_ACTIVE   = 8;
   localparam int H_FP       = 2;
   localparam int H_SYNC     = 2;
   localparam int H_BP       = 2;
   localparam int V_ACTIVE   = 4;
   localparam int V_FP       = 1;
   localparam int V_SYNC     = 1;
   localparam int V_BP       = 1;
   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic              clk = 1'b0;
   logic              rst;
   logic              vs, hs, de, locked, uf;
   logic [DATA_W-1:0] data;

   always #5 clk = ~clk;

   uiaxism2video_if #(.DATA_W(DATA_W)) axis_if ();

   uiaxism2video #(
      .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .vid_clk_i  (clk),
      .vid_rst_i  (rst),
      .s_axis_vid (axis_if),
      .vid_vs_o   (vs),
      .vid_hs_o   (hs),
      .vid_de_o   (de),
      .vid_data_o (data),
      .locked_o   (locked),
      .underflow_o(uf)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: a queue of buffered beats, a frame-lock flag and a
   // raster position derived arithmetically from cycles since reset.
   // ------------------------------------------------------------------
   typedef struct {
      logic [DATA_W-1:0] tdata;
      logic              tuser;
      logic              tlast;
   } beat_t;

   beat_t       mq[$];
   int          t_m;
   bit          locked_m, rdy_m;
   logic [36:0] exp_m;        // {vs, hs, de, locked, underflow, data}
   int          mh, mv, last_h, last_v;
   bit          m_act, n_uf, tr_exp, at_origin, at_eol;
   logic [31:0] n_data;
   beat_t       hd;

   // Observation logs used by the directed scenarios.
   logic [31:0] disp[$];
   int          uf_cnt, uf_h, uf_v, cyc, acc_cnt, rise_cyc, first_pix_cyc;
   bit          tr_prev;

   task automatic clear_logs();
      disp.delete();
      uf_cnt = 0; uf_h = -1; uf_v = -1; cyc = 0;
      acc_cnt = 0; rise_cyc = -1; first_pix_cyc = -1; tr_prev = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         check("reset_outputs", {26'b0, vs, hs, de, locked, uf, axis_if.tready, data}, 64'b0);
         mq.delete();
         t_m = 0; locked_m = 1'b0; rdy_m = 1'b0; exp_m = '0;
      end else begin
         tr_exp = rdy_m && (mq.size() < FIFO_DEPTH);
         check("cycle_outputs", {26'b0, vs, hs, de, locked, uf, data, axis_if.tready},
               {26'b0, exp_m, tr_exp});

         cyc++;
         if (uf) begin
            uf_cnt++; uf_h = last_h; uf_v = last_v;
         end
         if (de && locked) begin
            if (disp.size() == 0) first_pix_cyc = cyc;
            disp.push_back(data);
         end
         if (axis_if.tready && !tr_prev && acc_cnt >= FIFO_DEPTH && rise_cyc < 0) rise_cyc = cyc;
         tr_prev = axis_if.tready;
         if (axis_if.tvalid && axis_if.tready) acc_cnt++;

         mh        = t_m % H_TOTAL;
         mv        = (t_m / H_TOTAL) % V_TOTAL;
         m_act     = (mh < H_ACTIVE) && (mv < V_ACTIVE);
         at_origin = (mh == 0) && (mv == 0);
         at_eol    = (mh == H_ACTIVE - 1);
         n_uf      = 1'b0;
         n_data    = '0;
         if (!locked_m) begin
            // Searching: drop non-SOF beats, hold an SOF beat until the raster wraps.
            if (mq.size() > 0) begin
               if (!mq[0].tuser) void'(mq.pop_front());
               else if (mh == H_TOTAL - 1 && mv == V_TOTAL - 1) locked_m = 1'b1;
            end
         end else if (m_act) begin
            // Locked: the head beat must be exactly the one this pixel expects.
            if (mq.size() == 0) begin
               n_uf = 1'b1;
            end else begin
               hd = mq[0];
               if (hd.tuser && !at_origin) begin
                  n_uf = 1'b1;
               end else begin
                  void'(mq.pop_front());
                  if (hd.tuser == at_origin && hd.tlast == at_eol) n_data = hd.tdata;
                  else n_uf = 1'b1;
               end
            end
            if (n_uf) locked_m = 1'b0;
         end
         if (axis_if.tvalid && tr_exp)
            mq.push_back('{axis_if.tdata, axis_if.tuser, axis_if.tlast});
         exp_m = {(mv >= V_ACTIVE + V_FP) && (mv < V_ACTIVE + V_FP + V_SYNC),
                  (mh >= H_ACTIVE + H_FP) && (mh < H_ACTIVE + H_FP + H_SYNC),
                  m_act, locked_m, n_uf, n_data};
         last_h = mh; last_v = mv;
         t_m++;
         rdy_m = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Drivers
   // ------------------------------------------------------------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
      bit acc = 1'b0;
      axis_if.tdata  = d;
      axis_if.tuser  = u;
      axis_if.tlast  = l;
      axis_if.tvalid = 1'b1;
      for (int i = 0; i < 2000 && !acc; i++) begin
         @(negedge clk);
         acc = axis_if.tready;
         @(posedge clk); #1;
      end
      check("beat_accepted", {63'b0, acc}, 64'd1);
      axis_if.tvalid = 1'b0;
   endtask

   // bad_last < 0 gives tlast on every 8th beat; otherwise tlast only on that beat.
   task automatic send_frame(input logic [31:0] base, input int nbeats, input int bad_last,
                             input bit with_sof, input bit gaps);
      for (int i = 0; i < nbeats; i++) begin
         if (gaps && $urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
         send_beat(base + 32'(i), with_sof && (i == 0),
                   (bad_last < 0) ? ((i % H_ACTIVE) == H_ACTIVE - 1) : (i == bad_last));
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("async_reset", {26'b0, vs, hs, de, locked, uf, axis_if.tready, data}, 64'b0);
      axis_if.tvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic wait_disp(input string name, input int n, input int budget);
      for (int i = 0; i < budget && disp.size() < n; i++) idle(1);
      check(name, 64'(disp.size()), 64'(n));
   endtask

   task automatic wait_uf(input string name, input int budget);
      for (int i = 0; i < budget && uf_cnt == 0; i++) idle(1);
      check(name, 64'(uf_cnt), 64'd1);
   endtask

   // Reset timing table: edge number after reset release and expected outputs.
   typedef struct {
      int   edge_n;
      logic hs, vs, de, tready;
   } tvec_t;

   tvec_t tab[16];

   initial begin
      int n;
      tab[0]  = '{1,  1'b0, 1'b0, 1'b1, 1'b1};
      tab[1]  = '{8,  1'b0, 1'b0, 1'b1, 1'b1};
      tab[2]  = '{9,  1'b0, 1'b0, 1'b0, 1'b1};
      tab[3]  = '{11, 1'b1, 1'b0, 1'b0, 1'b1};
      tab[4]  = '{12, 1'b1, 1'b0, 1'b0, 1'b1};
      tab[5]  = '{13, 1'b0, 1'b0, 1'b0, 1'b1};
      tab[6]  = '{15, 1'b0, 1'b0, 1'b1, 1'b1};
      tab[7]  = '{25, 1'b1, 1'b0, 1'b0, 1'b1};
      tab[8]  = '{27, 1'b0, 1'b0, 1'b0, 1'b1};
      tab[9]  = '{57, 1'b0, 1'b0, 1'b0, 1'b1};
      tab[10] = '{70, 1'b0, 1'b0, 1'b0, 1'b1};
      tab[11] = '{71, 1'b0, 1'b1, 1'b0, 1'b1};
      tab[12] = '{81, 1'b1, 1'b1, 1'b0, 1'b1};
      tab[13] = '{84, 1'b0, 1'b1, 1'b0, 1'b1};
      tab[14] = '{85, 1'b0, 1'b0, 1'b0, 1'b1};
      tab[15] = '{99, 1'b0, 1'b0, 1'b1, 1'b1};

      axis_if.tdata = '0; axis_if.tuser = 1'b0; axis_if.tlast = 1'b0; axis_if.tvalid = 1'b0;
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      clear_logs();

      // 1. Timing generator after reset release, no stream traffic.
      n = 0;
      for (int k = 0; k < 16; k++) begin
         while (n < tab[k].edge_n) begin
            @(posedge clk);
            n++;
         end
         #2;
         check("timing_table", {26'b0, hs, vs, de, axis_if.tready, locked, data},
               {26'b0, tab[k].hs, tab[k].vs, tab[k].de, tab[k].tready, 1'b0, 32'b0});
      end

      // 2. Normal frame (reset asserted mid-frame).
      idle(20);
      do_reset();
      send_frame(32'd0, 32, -1, 1'b1, 1'b0);
      wait_disp("s2_pixel_count", 32, 400);
      for (int i = 0; i < disp.size(); i++) check("s2_pixel", 64'(disp[i]), 64'(i));
      check("s2_no_underflow", 64'(uf_cnt), 64'd0);

      // 3. Leading garbage is discarded.
      do_reset();
      for (int i = 0; i < 5; i++) send_beat(32'hA0 + 32'(i), 1'b0, 1'b0);
      send_frame(32'd0, 32, -1, 1'b1, 1'b0);
      wait_disp("s3_pixel_count", 32, 400);
      check("s3_first_pixel", 64'(disp[0]), 64'd0);
      check("s3_last_pixel", 64'(disp[31]), 64'd31);

      // 4. Starvation after 10 beats, then relock.
      do_reset();
      send_frame(32'd0, 10, -1, 1'b1, 1'b0);
      wait_uf("s4_underflow", 400);
      check("s4_uf_position", 64'(uf_v * 100 + uf_h), 64'd102);
      check("s4_unlocked", {63'b0, locked}, 64'd0);
      check("s4_shown", 64'(disp.size()), 64'd10);
      send_frame(32'h100, 32, -1, 1'b1, 1'b0);
      wait_disp("s4_relock_count", 42, 400);
      check("s4_relock_first", 64'(disp[10]), 64'h100);
      check("s4_relock_last", 64'(disp[41]), 64'h11F);

      // 5. Early tlast, then resync on the next tuser.
      do_reset();
      send_frame(32'd0, 32, 5, 1'b1, 1'b0);
      wait_uf("s5_underflow", 400);
      check("s5_uf_position", 64'(uf_v * 100 + uf_h), 64'd5);
      check("s5_unlocked", {63'b0, locked}, 64'd0);
      send_frame(32'h200, 32, -1, 1'b1, 1'b0);
      wait_disp("s5_resync_count", 37, 400);
      check("s5_resync_first", 64'(disp[5]), 64'h200);

      // 6. Backpressure: 20 beats pushed while the bridge waits for the frame boundary.
      do_reset();
      send_frame(32'd0, 20, -1, 1'b1, 1'b0);
      for (int i = 0; i < 400 && (rise_cyc < 0 || first_pix_cyc < 0); i++) idle(1);
      check("s6_ready_rise", 64'(rise_cyc), 64'(first_pix_cyc));
      check("s6_first_pixel", 64'(disp[0]), 64'd0);
      check("s6_accepted", 64'(acc_cnt), 64'd20);

      // 7. Randomized frames, gaps and framing errors against the model.
      do_reset();
      for (int f = 0; f < 12; f++) begin
         int kind;
         kind = $urandom_range(0, 4);
         for (int g = $urandom_range(0, 3); g > 0; g--) send_beat($urandom, 1'b0, $urandom_range(0, 1) == 1);
         case (kind)
            0: send_frame($urandom, 32, -1, 1'b1, 1'b1);
            1: send_frame($urandom, $urandom_range(1, 31), -1, 1'b1, 1'b0);
            2: send_frame($urandom, 32, $urandom_range(0, 31), 1'b1, 1'b0);
            3: send_frame($urandom, 32, -1, 1'b0, 1'b0);
            default: begin
               idle($urandom_range(0, 60));
               send_frame($urandom, 32, -1, 1'b1, 1'b0);
            end
         endcase
      end
      idle(300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
